// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory master.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: size encoding, FSM state encoding, WORD_BYTES, and helpers that
// turn (size, byte offset) into a byte count, an 8-lane mask spanning two
// consecutive words, and a word-boundary-crossing flag.
package lsu_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    RESP = 3'd5
  } state_e;

  // Number of bytes touched by an access; 0 for the illegal encoding.
  function automatic logic [2:0] size_bytes(size_e size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Bit i set => byte lane i of {word1, word0} is written by the access.
  function automatic logic [7:0] lane_mask(size_e size, logic [1:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  // The access spills into the next word when off + n exceeds one word.
  function automatic logic is_cross(size_e size, logic [1:0] off);
    return ({2'b00, off} + {1'b0, size_bytes(size)}) > 4'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment datapath: store merge into two read-back words, load extract/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   buf0, buf1   : words read back from w0 / w1 (buf1 only meaningful for crossing accesses)
//   wdata        : right-justified store data
//   off, size    : byte offset within w0 and access size
//   is_unsigned  : zero-extend sub-word loads
//   new0, new1   : merged words to write back at w0 / w1
//   rdata        : extracted and extended load result
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] buf0,
  input  logic [XLEN-1:0] buf1,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      off,
  input  size_e           size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] new0,
  output logic [XLEN-1:0] new1,
  output logic [XLEN-1:0] rdata
);

  logic [2*XLEN-1:0] old_w;
  logic [2*XLEN-1:0] wr_w;
  logic [2*XLEN-1:0] mrg_w;
  logic [XLEN-1:0]   rd_w;
  logic [7:0]        mask;
  logic [4:0]        shamt;

  always_comb begin
    shamt = {off, 3'b000};
    old_w = {buf1, buf0};
    // Store data is moved up to its byte offset; lanes outside the mask keep
    // whatever the SRAM returned, since the SRAM always writes all four lanes.
    wr_w  = {{XLEN{1'b0}}, wdata} << shamt;
    mask  = lane_mask(size, off);
    mrg_w = old_w;
    for (int i = 0; i < 2 * WORD_BYTES; i++) begin
      if (mask[i]) begin
        mrg_w[8*i +: 8] = wr_w[8*i +: 8];
      end
    end
    new0 = mrg_w[XLEN-1:0];
    new1 = mrg_w[2*XLEN-1:XLEN];

    rd_w = XLEN'(old_w >> shamt);
    case (size)
      SZ_B:    rdata = {{(XLEN-8){~is_unsigned & rd_w[7]}}, rd_w[7:0]};
      SZ_H:    rdata = {{(XLEN-16){~is_unsigned & rd_w[15]}}, rd_w[15:0]};
      default: rdata = rd_w;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide SRAM: sub-word stores via read-modify-write, optional split of crossing accesses.
// Latency: rsp 1 cycle after accept (error), 2 (aligned load / full word store), 3 (crossing load, partial store), up to 5.
// Backpressure: req_ready only in IDLE, one request in flight; response is a pulse with no backpressure.
//
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   req_*             : one request, latched when req_valid && req_ready
//   rsp_valid/rdata/err : registered one-cycle response
//   mem_*             : registered SRAM strobes; mem_data_out is read combinationally
// Build option: define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into
// two word accesses; otherwise crossing requests return rsp_err with no memory access.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [XLEN-1:0]   mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [XLEN-1:0]   mem_data_out
);

  state_e            state, state_nxt;

  logic              lat_we, lat_uns;
  size_e             lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [XLEN-1:0]   lat_wdata;
  logic [XLEN-1:0]   buf0, buf1;

  logic              cur_we, cur_uns;
  size_e             cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [XLEN-1:0]   cur_wdata;
  logic [1:0]        cur_off;
  logic              cur_cross, split_cross, bad_now, accept;
  logic [ADDR_W-1:0] w0, w1;

  logic [XLEN-1:0]   buf0_d, buf1_d, new0, new1, ld_data;

  logic              mem_read_d, mem_write_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_W-1:0] mem_address_d;
  logic [XLEN-1:0]   mem_data_in_d, rsp_rdata_d;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Outputs are registered from the next state, so on the accepting edge the
  // datapath must already see the incoming request rather than the latch.
  assign cur_we    = (state == IDLE) ? req_we            : lat_we;
  assign cur_uns   = (state == IDLE) ? req_unsigned      : lat_uns;
  assign cur_size  = (state == IDLE) ? size_e'(req_size) : lat_size;
  assign cur_addr  = (state == IDLE) ? req_addr          : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata         : lat_wdata;

  assign cur_off   = cur_addr[1:0];
  assign cur_cross = is_cross(cur_size, cur_off);
  assign w0        = {cur_addr[ADDR_W-1:2], 2'b00};
  assign w1        = w0 + ADDR_W'(WORD_BYTES);   // wraps at the top of the address space

`ifdef LSU_MISALIGN_SPLIT_EN
  assign split_cross = cur_cross;
  assign bad_now     = (cur_size == SZ_BAD);
`else
  assign split_cross = 1'b0;
  assign bad_now     = (cur_size == SZ_BAD) || cur_cross;
`endif

  // Read data becomes visible in the same cycle as the address, so the word
  // being read this cycle is forwarded straight into the merge/extract path.
  assign buf0_d = (state == RD0) ? mem_data_out : buf0;
  assign buf1_d = (state == RD1) ? mem_data_out : buf1;

  lsu_align #(.XLEN(XLEN)) u_align (
    .buf0        (buf0_d),
    .buf1        (buf1_d),
    .wdata       (cur_wdata),
    .off         (cur_off),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .new0        (new0),
    .new1        (new1),
    .rdata       (ld_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad_now)                                      state_nxt = RESP;
          else if (!cur_we)                                 state_nxt = RD0;
          // A full aligned word replaces every lane, so no read-back is needed.
          else if (cur_size == SZ_W && cur_off == 2'd0)     state_nxt = WR0;
          else                                              state_nxt = RD0;
        end
      end
      RD0:     state_nxt = split_cross ? RD1 : (cur_we ? WR0 : RESP);
      RD1:     state_nxt = cur_we ? WR0 : RESP;
      WR0:     state_nxt = split_cross ? WR1 : RESP;
      WR1:     state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = '0;
    mem_data_in_d = '0;
    rsp_valid_d   = (state_nxt == RESP);
    rsp_err_d     = accept && bad_now;
    rsp_rdata_d   = '0;
    case (state_nxt)
      RD0: begin
        mem_read_d    = 1'b1;
        mem_address_d = w0;
      end
      RD1: begin
        mem_read_d    = 1'b1;
        mem_address_d = w1;
      end
      WR0: begin
        mem_write_d   = 1'b1;
        mem_address_d = w0;
        mem_data_in_d = new0;
      end
      WR1: begin
        mem_write_d   = 1'b1;
        mem_address_d = w1;
        mem_data_in_d = new1;
      end
      RESP: begin
        // Only loads that actually went to memory return data.
        if (state != IDLE && !cur_we) rsp_rdata_d = ld_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_uns     <= 1'b0;
      lat_size    <= SZ_B;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      buf0        <= '0;
      buf1        <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_uns   <= req_unsigned;
        lat_size  <= size_e'(req_size);
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      buf0        <= buf0_d;
      buf1        <= buf1_d;
      mem_read    <= mem_read_d;
      mem_write   <= mem_write_d;
      mem_address <= mem_address_d;
      mem_data_in <= mem_data_in_d;
      rsp_valid   <= rsp_valid_d;
      rsp_err     <= rsp_err_d;
      rsp_rdata   <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed vector table plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_lsu_mem_master;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read, mem_write;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(32), .XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out)
  );

  // SRAM model: 256 words indexed by address bits [9:2]; all addresses used
  // by the bench map to distinct words.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:2]] <= mem_data_in;
  end
  assign mem_data_out = mem[mem_address[9:2]];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_rd, input int exp_wr);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_lat = exp_lat; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
    vecs.push_back(v);
  endfunction

  // Results of the most recent run_req
  logic [31:0] t_rdata;
  logic        t_err;
  int          t_lat, t_rd, t_wr, t_both, t_misal, t_first_rd, t_first_wr;
  logic [31:0] t_wa [0:3];

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    @(negedge clk);
    check({tag, " ready_before"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    t_rd = 0; t_wr = 0; t_both = 0; t_misal = 0; t_first_rd = -1; t_first_wr = -1;
    t_lat = -1; t_rdata = 32'hxxxxxxxx; t_err = 1'bx;
    for (int i = 0; i < 4; i++) t_wa[i] = 32'hDEADDEAD;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid) begin
        t_lat = k; t_rdata = rsp_rdata; t_err = rsp_err;
        break;
      end
      if (mem_read) begin
        t_rd++;
        if (t_first_rd < 0) t_first_rd = k;
      end
      if (mem_write) begin
        if (t_wr < 4) t_wa[t_wr] = mem_address;
        t_wr++;
        if (t_first_wr < 0) t_first_wr = k;
      end
      if (mem_read && mem_write) t_both++;
      if ((mem_read || mem_write) && mem_address[1:0] != 2'b00) t_misal++;
      @(posedge clk);
      #1;
    end
    if (t_lat < 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: rsp_valid not seen within 20 cycles", tag);
    end else begin
      @(posedge clk);
      #1;
      check({tag, " rsp_pulse_end"}, {31'b0, rsp_valid}, 32'd0);
      check({tag, " ready_after"}, {31'b0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;

    //  we size uns addr          wdata          exp_rdata                          err      lat          rd           wr
    add(1, 2, 0, 32'h0000_0100, 32'h1122_3344, 32'h0,                             0,       2,           0,           1);
    add(0, 0, 0, 32'h0000_0103, 32'h0,         32'h0000_0011,                     0,       2,           1,           0);
    add(0, 1, 0, 32'h0000_0102, 32'h0,         32'h0000_1122,                     0,       2,           1,           0);
    add(1, 2, 0, 32'h0000_0080, 32'h0000_F0A5, 32'h0,                             0,       2,           0,           1);
    add(0, 0, 0, 32'h0000_0080, 32'h0,         32'hFFFF_FFA5,                     0,       2,           1,           0);
    add(0, 0, 1, 32'h0000_0080, 32'h0,         32'h0000_00A5,                     0,       2,           1,           0);
    add(0, 1, 0, 32'h0000_0080, 32'h0,         32'hFFFF_F0A5,                     0,       2,           1,           0);
    add(0, 1, 1, 32'h0000_0080, 32'h0,         32'h0000_F0A5,                     0,       2,           1,           0);
    add(1, 2, 0, 32'h0000_0200, 32'hAABB_CCDD, 32'h0,                             0,       2,           0,           1);
    add(1, 0, 0, 32'h0000_0201, 32'hFFFF_FF5E, 32'h0,                             0,       3,           1,           1);
    add(0, 2, 0, 32'h0000_0200, 32'h0,         32'hAABB_5EDD,                     0,       2,           1,           0);
    add(1, 2, 0, 32'h0000_0010, 32'h4433_2211, 32'h0,                             0,       2,           0,           1);
    add(1, 2, 0, 32'h0000_0014, 32'h8877_6655, 32'h0,                             0,       2,           0,           1);
    add(0, 2, 0, 32'h0000_0012, 32'h0,         SPLIT ? 32'h6655_4433 : 32'h0,     !SPLIT,  SPLIT ? 3:1, SPLIT ? 2:0, 0);
    add(0, 1, 1, 32'h0000_0013, 32'h0,         SPLIT ? 32'h0000_5544 : 32'h0,     !SPLIT,  SPLIT ? 3:1, SPLIT ? 2:0, 0);
    add(0, 1, 0, 32'h0000_0016, 32'h0,         32'hFFFF_8877,                     0,       2,           1,           0);
    add(1, 2, 0, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0,                             0,       2,           0,           1);
    add(1, 2, 0, 32'h0000_0000, 32'h9ABC_DEF0, 32'h0,                             0,       2,           0,           1);
    add(1, 1, 0, 32'hFFFF_FFFF, 32'h0000_BEEF, 32'h0,                             !SPLIT,  SPLIT ? 5:1, SPLIT ? 2:0, SPLIT ? 2:0);
    add(0, 2, 0, 32'hFFFF_FFFC, 32'h0,         SPLIT ? 32'hEF34_5678 : 32'h1234_5678, 0, 2,         1,           0);
    add(0, 2, 0, 32'h0000_0000, 32'h0,         SPLIT ? 32'h9ABC_DEBE : 32'h9ABC_DEF0, 0, 2,         1,           0);
    add(0, 0, 1, 32'hFFFF_FFFF, 32'h0,         SPLIT ? 32'h0000_00EF : 32'h0000_0012, 0, 2,         1,           0);
    add(0, 3, 0, 32'h0000_0100, 32'h0,         32'h0,                             1,       1,           0,           0);
    add(1, 3, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,                             1,       1,           0,           0);
    add(0, 2, 0, 32'h0000_0100, 32'h0,         32'h1122_3344,                     0,       2,           1,           0);
    add(1, 1, 0, 32'h0000_0102, 32'h0000_5566, 32'h0,                             0,       3,           1,           1);
    add(0, 2, 0, 32'h0000_0100, 32'h0,         32'h5566_3344,                     0,       2,           1,           0);
    add(1, 2, 0, 32'h0000_0013, 32'hA1B2_C3D4, 32'h0,                             !SPLIT,  SPLIT ? 5:1, SPLIT ? 2:0, SPLIT ? 2:0);
    add(0, 2, 0, 32'h0000_0010, 32'h0,         SPLIT ? 32'hD433_2211 : 32'h4433_2211, 0, 2,         1,           0);
    add(0, 2, 0, 32'h0000_0014, 32'h0,         SPLIT ? 32'h88A1_B2C3 : 32'h8877_6655, 0, 2,         1,           0);
    add(0, 2, 1, 32'h0000_0014, 32'h0,         SPLIT ? 32'h88A1_B2C3 : 32'h8877_6655, 0, 2,         1,           0);
    add(0, 0, 0, 32'h0000_0017, 32'h0,         32'hFFFF_FF88,                     0,       2,           1,           0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready",   {31'b0, req_ready}, 32'd1);
    check("reset rsp_valid",   {31'b0, rsp_valid}, 32'd0);
    check("reset rsp_err",     {31'b0, rsp_err},   32'd0);
    check("reset rsp_rdata",   rsp_rdata,          32'd0);
    check("reset mem_read",    {31'b0, mem_read},  32'd0);
    check("reset mem_write",   {31'b0, mem_write}, 32'd0);
    check("reset mem_address", mem_address,        32'd0);
    check("reset mem_data_in", mem_data_in,        32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              $sformatf("v%0d", i));
      check($sformatf("v%0d rdata", i),  t_rdata,                 vecs[i].exp_rdata);
      check($sformatf("v%0d err", i),    {31'b0, t_err},          {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d latency", i), t_lat,                  vecs[i].exp_lat);
      check($sformatf("v%0d reads", i),  t_rd,                    vecs[i].exp_rd);
      check($sformatf("v%0d writes", i), t_wr,                    vecs[i].exp_wr);
      check($sformatf("v%0d rd_and_wr", i), t_both,               32'd0);
      check($sformatf("v%0d addr_align", i), t_misal,             32'd0);
    end

    // Byte store: a single write pulse, preceded by the read-back
    run_req(1'b1, 2'd0, 1'b0, 32'h0000_0202, 32'h0000_0077, "sb202");
    check("sb202 writes", t_wr, 32'd1);
    check("sb202 read_first", {31'b0, (t_first_rd > 0) && (t_first_rd < t_first_wr)}, 32'd1);
    check("sb202 wr_addr", t_wa[0], 32'h0000_0200);
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, "lw200");
    check("lw200 rdata", t_rdata, 32'hAA77_5EDD);

    // Crossing half store at the top of memory: second word wraps to 0
    run_req(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_CAFE, "shtop");
    check("shtop wr_addr0", t_wa[0], SPLIT ? 32'hFFFF_FFFC : 32'hDEADDEAD);
    check("shtop wr_addr1", t_wa[1], SPLIT ? 32'h0000_0000 : 32'hDEADDEAD);
    check("shtop err", {31'b0, t_err}, {31'b0, !SPLIT});
    run_req(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, "lwtop");
    check("lwtop rdata", t_rdata, SPLIT ? 32'hFE34_5678 : 32'h1234_5678);
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, "lwzero");
    check("lwzero rdata", t_rdata, SPLIT ? 32'h9ABC_DECA : 32'h9ABC_DEF0);

    // Reset landing in WR0 of a full word store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0000_0300; req_wdata = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("wr0 mem_write_before_reset", {31'b0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_wr0 mem_write",   {31'b0, mem_write}, 32'd0);
    check("rst_wr0 req_ready",   {31'b0, req_ready}, 32'd1);
    check("rst_wr0 rsp_valid",   {31'b0, rsp_valid}, 32'd0);
    check("rst_wr0 mem_address", mem_address,        32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, "post_rst");
    check("post_rst rdata", t_rdata, 32'h5566_3344);
    check("post_rst latency", t_lat, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
